// File: rtl/controlpath_seq_pkg.sv
// Shared definitions for the multi-cycle control path: opcodes, FSM states,
// load-source encodings, branch condition codes and small decode helpers.
package cp_pkg;

   localparam logic [3:0] OPC_LD   = 4'h8;
   localparam logic [3:0] OPC_ST   = 4'h9;
   localparam logic [3:0] OPC_PUSH = 4'hA;
   localparam logic [3:0] OPC_POP  = 4'hB;
   localparam logic [3:0] OPC_BR   = 4'hC;
   localparam logic [3:0] OPC_PLOT = 4'hD;
   localparam logic [3:0] OPC_NOP  = 4'hE;
   localparam logic [3:0] OPC_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_PLOT,
      ST_HALT
   } cp_state_t;

   localparam logic [1:0] LSRC_SELF = 2'd0;
   localparam logic [1:0] LSRC_ALU  = 2'd1;
   localparam logic [1:0] LSRC_MEM  = 2'd2;
   localparam logic [1:0] LSRC_STK  = 2'd3;

   localparam logic [1:0] COND_ZERO = 2'd0;
   localparam logic [1:0] COND_SIGN = 2'd1;
   localparam logic [1:0] COND_OVF  = 2'd2;
   localparam logic [1:0] COND_ERR  = 2'd3;

   function automatic logic is_alu_op(input logic [3:0] opc);
      return (opc[3] == 1'b0);
   endfunction

   function automatic logic is_mem_op(input logic [3:0] opc);
      return (opc == OPC_LD) || (opc == OPC_ST) || (opc == OPC_PUSH) || (opc == OPC_POP);
   endfunction

   function automatic logic is_load_op(input logic [3:0] opc);
      return (opc == OPC_LD) || (opc == OPC_POP);
   endfunction

endpackage

// File: rtl/controlpath_seq_if.sv
// Memory / VGA request-acknowledge bus between the control path (master)
// and the memory and VGA blocks (slave).
interface controlpath_seq_if;
   logic mem_req;
   logic mem_we;
   logic mem_stk;
   logic mem_ack;
   logic vga_plot;
   logic vga_ack;

   modport master (
      output mem_req, mem_we, mem_stk, vga_plot,
      input  mem_ack, vga_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_stk, vga_plot,
      output mem_ack, vga_ack
   );
endinterface

// File: rtl/controlpath_seq_timer.sv
// Handshake wait timer shared by the MEM and PLOT states. Down-counter loaded
// with TIMEOUT-1 when a wait state is entered; expiry is reported on the
// wait cycle where the count has reached zero, i.e. the TIMEOUT-th wait cycle.
module cp_handshake_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic run,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt;

   // load on wait-state entry, count down while waiting, park at zero
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= CNT_W'(TIMEOUT - 1);
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expired = run && (cnt == '0);

endmodule

// File: rtl/controlpath_seq.sv
// Multi-cycle fetch/decode/execute/memory/writeback controller between the
// IR and the ALU/regfile/VGA datapath.
// Optional build macro: CONTROLPATH_STEP_MODE_EN -- when defined, FETCH only
// advances on a step pulse together with instr_valid.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_FETCH  | wait for a valid instruction, latch it into the internal IR
// ST_DECODE | register operand selects and ALU op
// ST_EXEC   | dispatch; branches resolve here
// ST_MEM    | memory/stack request until ack or timeout
// ST_WB     | one-cycle register write and PC increment
// ST_PLOT   | VGA plot request until ack or timeout
// ST_HALT   | stopped; only reset leaves
module controlpath_seq
   import cp_pkg::*;
#(
   parameter int INSTR_W = 16,
   parameter int NREG    = 16,
   parameter int TIMEOUT = 15,
   localparam int SEL_W  = $clog2(NREG)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   input  logic [NREG-1:0]    zeroflag,
   input  logic [NREG-1:0]    signflag,
   input  logic [NREG-1:0]    overflow,
   input  logic [NREG-1:0]    errorbit,
   input  logic               step,
   output logic               pc_inc,
   output logic               pc_load,
   output logic [3:0]         alu_op,
   output logic [SEL_W-1:0]   alu_a_sel,
   output logic [SEL_W-1:0]   alu_b_sel,
   output logic [SEL_W-1:0]   alu_out_sel,
   output logic               reg_we,
   output logic [1:0]         load_src,
   output logic               halted,
   output logic               bus_timeout,
   controlpath_seq_if.master  bus
);

   cp_state_t          state, state_nx;
   logic [INSTR_W-1:0] ir;
   logic [3:0]         opc, fld_c, fld_a, fld_b;
   logic               fetch_go;
   logic [NREG-1:0]    flag_vec;
   logic               br_taken;
   logic               timer_start, timer_run, timer_expired, timeout_hit;
   logic               mem_req_c, mem_we_c, mem_stk_c, vga_plot_c;

   assign opc   = ir[15:12];
   assign fld_c = ir[11:8];
   assign fld_a = ir[7:4];
   assign fld_b = ir[3:0];

`ifdef CONTROLPATH_STEP_MODE_EN
   assign fetch_go = instr_valid && step;
`else
   logic unused_step;
   assign unused_step = step;
   assign fetch_go    = instr_valid;
`endif

   cp_handshake_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clock   (clock),
      .reset   (reset),
      .start   (timer_start),
      .run     (timer_run),
      .expired (timer_expired)
   );

   // state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_FETCH;
      end else begin
         state <= state_nx;
      end
   end

   // instruction latch, registered operand selects and sticky timeout flag
   always_ff @(posedge clock) begin
      if (reset) begin
         ir          <= '0;
         alu_op      <= '0;
         alu_a_sel   <= '0;
         alu_b_sel   <= '0;
         alu_out_sel <= '0;
         bus_timeout <= 1'b0;
      end else begin
         if ((state == ST_FETCH) && fetch_go) begin
            ir <= instr;
         end
         if (state == ST_DECODE) begin
            alu_op      <= is_alu_op(opc) ? opc : 4'h0;
            alu_a_sel   <= SEL_W'(fld_a);
            alu_b_sel   <= SEL_W'(fld_b);
            alu_out_sel <= SEL_W'(fld_c);
         end
         if (timeout_hit) begin
            bus_timeout <= 1'b1;
         end
      end
   end

   // branch condition: flag of register B chosen by A[1:0]; out-of-range B is never taken
   always_comb begin
      case (fld_a[1:0])
         COND_SIGN: flag_vec = signflag;
         COND_OVF:  flag_vec = overflow;
         COND_ERR:  flag_vec = errorbit;
         default:   flag_vec = zeroflag;
      endcase
      br_taken = 1'b0;
      if (int'(fld_b) < NREG) begin
         br_taken = flag_vec[fld_b];
      end
   end

   // next state and strobes; ack wins over a timeout expiring in the same cycle
   always_comb begin
      state_nx    = state;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      reg_we      = 1'b0;
      load_src    = LSRC_SELF;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      mem_stk_c   = 1'b0;
      vga_plot_c  = 1'b0;
      halted      = 1'b0;
      timer_start = 1'b0;
      timer_run   = 1'b0;
      timeout_hit = 1'b0;
      unique case (state)
         ST_FETCH: begin
            if (fetch_go) state_nx = ST_DECODE;
         end
         ST_DECODE: begin
            state_nx = ST_EXEC;
         end
         ST_EXEC: begin
            if (is_alu_op(opc) || (opc == OPC_NOP)) begin
               state_nx = ST_WB;
            end else if (is_mem_op(opc)) begin
               state_nx    = ST_MEM;
               timer_start = 1'b1;
            end else if (opc == OPC_BR) begin
               state_nx = ST_FETCH;
               pc_load  = br_taken;
               pc_inc   = !br_taken;
            end else if (opc == OPC_PLOT) begin
               state_nx    = ST_PLOT;
               timer_start = 1'b1;
            end else begin
               state_nx = ST_HALT;
            end
         end
         ST_MEM: begin
            mem_req_c = 1'b1;
            mem_we_c  = (opc == OPC_ST) || (opc == OPC_PUSH);
            mem_stk_c = (opc == OPC_PUSH) || (opc == OPC_POP);
            timer_run = 1'b1;
            if (bus.mem_ack) begin
               if (is_load_op(opc)) begin
                  state_nx = ST_WB;
               end else begin
                  state_nx = ST_FETCH;
                  pc_inc   = 1'b1;
               end
            end else if (timer_expired) begin
               state_nx    = ST_FETCH;
               pc_inc      = 1'b1;
               timeout_hit = 1'b1;
            end
         end
         ST_WB: begin
            reg_we   = 1'b1;
            pc_inc   = 1'b1;
            state_nx = ST_FETCH;
            if (is_alu_op(opc))        load_src = LSRC_ALU;
            else if (opc == OPC_LD)    load_src = LSRC_MEM;
            else if (opc == OPC_POP)   load_src = LSRC_STK;
            else                       load_src = LSRC_SELF;
         end
         ST_PLOT: begin
            vga_plot_c = 1'b1;
            timer_run  = 1'b1;
            if (bus.vga_ack) begin
               state_nx = ST_FETCH;
               pc_inc   = 1'b1;
            end else if (timer_expired) begin
               state_nx    = ST_FETCH;
               pc_inc      = 1'b1;
               timeout_hit = 1'b1;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_nx = ST_FETCH;
         end
      endcase
   end

   assign bus.mem_req  = mem_req_c;
   assign bus.mem_we   = mem_we_c;
   assign bus.mem_stk  = mem_stk_c;
   assign bus.vga_plot = vga_plot_c;

endmodule
